// File: rtl/hdlc_tx_framer_pkg.sv
// Shared definitions for the HDLC transmit framer.
//   HDLC_FLAG  : frame delimiter, sent without bit stuffing
//   HDLC_ABORT : abort sequence byte, sent without bit stuffing
//   CRC_POLY   : CCITT generator polynomial (x^16 + x^12 + x^5 + 1)
//   state_t    : framer FSM state encoding
package hdlc_tx_framer_pkg;

  localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
  localparam logic [7:0]  HDLC_ABORT = 8'hFF;
  localparam logic [15:0] CRC_POLY   = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPEN    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC_HI  = 3'd3,
    ST_CRC_LO  = 3'd4,
    ST_CLOSE   = 3'd5,
    ST_ABORT   = 3'd6,
    ST_DROP    = 3'd7
  } state_t;

endpackage

// File: rtl/hdlc_tx_framer_crc16.sv
// Combinational byte-wide CRC-16/CCITT update, MSB first, no reflection.
// Ports:
//   crc_in  [15:0] in  : current CRC register
//   byte_in [7:0]  in  : byte being folded into the CRC
//   crc_out [15:0] out : CRC after absorbing byte_in
module crc16_ccitt_byte
  import hdlc_tx_framer_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  // One bit of the serial LFSR; unrolled eight times below.
  function automatic logic [15:0] crc_bit_step(input logic [15:0] c);
    crc_bit_step = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
  endfunction

  always_comb begin
    crc_out = crc_in ^ {byte_in, 8'h00};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_bit_step(crc_out);
    end
  end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit frame sequencer feeding a byte serializer.
// Emits: OPEN_FLAGS x 7E, payload, CRC hi, CRC lo, 7E. Abort sends FF.
// Ports:
//   clk, reset          : clock (posedge) and asynchronous active-high reset
//   in_data/in_valid/in_last/in_ready : payload byte stream from the source
//   abort               : level request to abort the current frame
//   ser_data/ser_strobe/ser_stuff     : byte, load strobe, stuffing enable to serializer
//   ser_ready           : serializer can take a new byte
//   busy                : frame in progress (until closing flag / abort byte sent)
//   frame_done          : pulse when closing flag handed over
//   frame_aborted       : pulse when abort byte handed over
module hdlc_tx_framer
  import hdlc_tx_framer_pkg::*;
#(
  parameter int          OPEN_FLAGS = 1,
  parameter bit          IDLE_FLAGS = 1'b0,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] ser_data,
  output logic       ser_strobe,
  output logic       ser_stuff,
  input  logic       ser_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_aborted
);

  localparam logic [3:0] LAST_FLAG = 4'(OPEN_FLAGS - 1);

  state_t      state;
  logic [3:0]  flag_cnt;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        abort_to_idle;
  logic        slot;

  // A slot is a cycle where the serializer is ready and we did not just
  // strobe it (its ready drops one cycle after our strobe).
  assign slot = ser_ready && !ser_strobe;

  // An abort on a payload slot takes priority, so the byte is not consumed.
  assign in_ready = slot && ((state == ST_PAYLOAD && !abort) || state == ST_DROP);

  crc16_ccitt_byte u_crc (
    .crc_in  (crc),
    .byte_in (in_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      flag_cnt      <= 4'd0;
      crc           <= CRC_INIT;
      abort_to_idle <= 1'b0;
      ser_data      <= 8'hFF;
      ser_stuff     <= 1'b0;
      ser_strobe    <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
    end else begin
      ser_strobe    <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            crc      <= CRC_INIT;
            flag_cnt <= 4'd0;
            busy     <= 1'b1;
            state    <= ST_OPEN;
          end else if (IDLE_FLAGS && slot) begin
            ser_data   <= HDLC_FLAG;
            ser_stuff  <= 1'b0;
            ser_strobe <= 1'b1;
          end
        end

        ST_OPEN: begin
          if (slot) begin
            if (abort) begin
              abort_to_idle <= 1'b0;
              state         <= ST_ABORT;
            end else begin
              ser_data   <= HDLC_FLAG;
              ser_stuff  <= 1'b0;
              ser_strobe <= 1'b1;
              if (flag_cnt == LAST_FLAG) begin
                state <= ST_PAYLOAD;
              end else begin
                flag_cnt <= flag_cnt + 4'd1;
              end
            end
          end
        end

        ST_PAYLOAD: begin
          if (slot) begin
            if (abort) begin
              abort_to_idle <= 1'b0;
              state         <= ST_ABORT;
            end else if (!in_valid) begin
              // Underrun: the source has nothing else, so nothing to drop.
              abort_to_idle <= 1'b1;
              state         <= ST_ABORT;
            end else begin
              ser_data   <= in_data;
              ser_stuff  <= 1'b1;
              ser_strobe <= 1'b1;
              crc        <= crc_next;
              if (in_last) begin
                state <= ST_CRC_HI;
              end
            end
          end
        end

        ST_CRC_HI: begin
          if (slot) begin
            if (abort) begin
              abort_to_idle <= 1'b1;
              state         <= ST_ABORT;
            end else begin
              ser_data   <= crc[15:8];
              ser_stuff  <= 1'b1;
              ser_strobe <= 1'b1;
              state      <= ST_CRC_LO;
            end
          end
        end

        ST_CRC_LO: begin
          if (slot) begin
            if (abort) begin
              abort_to_idle <= 1'b1;
              state         <= ST_ABORT;
            end else begin
              ser_data   <= crc[7:0];
              ser_stuff  <= 1'b1;
              ser_strobe <= 1'b1;
              state      <= ST_CLOSE;
            end
          end
        end

        ST_CLOSE: begin
          if (slot) begin
            ser_data   <= HDLC_FLAG;
            ser_stuff  <= 1'b0;
            ser_strobe <= 1'b1;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        ST_ABORT: begin
          if (slot) begin
            ser_data      <= HDLC_ABORT;
            ser_stuff     <= 1'b0;
            ser_strobe    <= 1'b1;
            frame_aborted <= 1'b1;
            busy          <= 1'b0;
            state         <= abort_to_idle ? ST_IDLE : ST_DROP;
          end
        end

        ST_DROP: begin
          // Swallow the rest of the aborted frame up to its last byte.
          if (slot && in_valid && in_last) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
module tb_hdlc_tx_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       abort;
  logic [7:0] ser_data;
  logic       ser_strobe;
  logic       ser_stuff;
  logic       ser_ready;
  logic       busy;
  logic       frame_done;
  logic       frame_aborted;

  logic [7:0] s2_data;
  logic       s2_strobe, s2_stuff, s2_in_ready, s2_busy, s2_done, s2_aborted;

  always #5 clk = ~clk;

  hdlc_tx_framer #(.OPEN_FLAGS(1), .IDLE_FLAGS(1'b0), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .abort(abort),
    .ser_data(ser_data), .ser_strobe(ser_strobe), .ser_stuff(ser_stuff), .ser_ready(ser_ready),
    .busy(busy), .frame_done(frame_done), .frame_aborted(frame_aborted)
  );

  // Second instance: idle-flag mode, always-ready serializer, no source.
  hdlc_tx_framer #(.OPEN_FLAGS(3), .IDLE_FLAGS(1'b1), .CRC_INIT(16'hFFFF)) dut_idle (
    .clk(clk), .reset(reset),
    .in_data(8'h00), .in_valid(1'b0), .in_last(1'b0), .in_ready(s2_in_ready),
    .abort(1'b0),
    .ser_data(s2_data), .ser_strobe(s2_strobe), .ser_stuff(s2_stuff), .ser_ready(1'b1),
    .busy(s2_busy), .frame_done(s2_done), .frame_aborted(s2_aborted)
  );

  // Serializer model: busy for a few cycles after each strobe.
  int sh_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_ready <= 1'b1;
      sh_cnt    <= 0;
    end else if (ser_strobe) begin
      ser_ready <= 1'b0;
      sh_cnt    <= 3;
    end else if (sh_cnt != 0) begin
      sh_cnt <= sh_cnt - 1;
      if (sh_cnt == 1) ser_ready <= 1'b1;
    end
  end

  // Monitor, sampled on the falling edge.
  logic [8:0] cap[$];
  int n_done = 0, n_abort = 0, dbl = 0, s2_cnt = 0, s2_bad = 0;
  logic prev_strb = 1'b0, s2_prev = 1'b0;
  always @(negedge clk) begin
    if (ser_strobe) cap.push_back({ser_stuff, ser_data});
    if (ser_strobe && prev_strb) dbl++;
    prev_strb = ser_strobe;
    if (frame_done) n_done++;
    if (frame_aborted) n_abort++;
    if (s2_strobe) begin
      s2_cnt++;
      if ({s2_stuff, s2_data} != 9'h07E) s2_bad++;
    end
    if (s2_strobe && s2_prev) dbl++;
    s2_prev = s2_strobe;
  end

  int n_cmp = 0, n_fail = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic cmp_seq(input string nm, input int base);
    int got_n;
    got_n = cap.size() - base;
    check({nm, "_len"}, got_n, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < cap.size(); i++)
      check($sformatf("%s_b%0d", nm, i), {23'd0, cap[base+i]}, {23'd0, exp_q[i]});
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) check("push_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_pulses(input string nm, input int d_target, input int a_target);
    int t;
    t = 0;
    while ((n_done < d_target || n_abort < a_target) && t < 500) begin @(negedge clk); t++; end
    check({nm, "_wait"}, (n_done >= d_target && n_abort >= a_target), 1);
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [7:0]  pl[10];
    logic [15:0] crc;
  } vec_t;
  vec_t tv[4];

  task automatic exp_frame(input int idx);
    exp_q.push_back(9'h07E);
    for (int i = 0; i < tv[idx].n; i++) exp_q.push_back({1'b1, tv[idx].pl[i]});
    exp_q.push_back({1'b1, tv[idx].crc[15:8]});
    exp_q.push_back({1'b1, tv[idx].crc[7:0]});
    exp_q.push_back(9'h07E);
  endtask

  task automatic send_frame(input int idx);
    for (int i = 0; i < tv[idx].n; i++) push_byte(tv[idx].pl[i], (i == tv[idx].n - 1));
  endtask

  initial begin
    int base, d0, a0, c0;
    tv[0].n = 9; tv[0].pl = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h00}; tv[0].crc = 16'h29B1;
    tv[1].n = 1; tv[1].pl = '{8'hFF,0,0,0,0,0,0,0,0,0}; tv[1].crc = 16'hFF00;
    tv[2].n = 1; tv[2].pl = '{8'h00,0,0,0,0,0,0,0,0,0}; tv[2].crc = 16'hE1F0;
    tv[3].n = 1; tv[3].pl = '{8'h41,0,0,0,0,0,0,0,0,0}; tv[3].crc = 16'hB915;

    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_ser_data", ser_data, 8'hFF);
    check("rst_strobe", ser_strobe, 0);
    check("rst_stuff", ser_stuff, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_aborted", frame_aborted, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Idle line with IDLE_FLAGS=0: nothing strobed.
    check("idle_no_strobe", cap.size(), 0);

    // Idle-flag instance: one flag every other cycle.
    c0 = s2_cnt;
    repeat (20) @(negedge clk);
    check("idleflags_count", s2_cnt - c0, 10);

    // Table-driven complete frames.
    for (int k = 0; k < 4; k++) begin
      base = cap.size(); d0 = n_done; a0 = n_abort;
      exp_q.delete();
      exp_frame(k);
      send_frame(k);
      in_valid = 1'b0; in_last = 1'b0;
      wait_pulses($sformatf("frame%0d", k), d0 + 1, a0);
      cmp_seq($sformatf("frame%0d", k), base);
      check($sformatf("frame%0d_done", k), n_done - d0, 1);
      check($sformatf("frame%0d_abort", k), n_abort - a0, 0);
      check($sformatf("frame%0d_busy", k), busy, 0);
    end

    // Underrun after 2 of 4 bytes.
    base = cap.size(); d0 = n_done; a0 = n_abort;
    exp_q.delete();
    exp_q.push_back(9'h07E); exp_q.push_back(9'h1A0); exp_q.push_back(9'h1A1); exp_q.push_back(9'h0FF);
    push_byte(8'hA0, 1'b0);
    push_byte(8'hA1, 1'b0);
    in_valid = 1'b0;
    wait_pulses("underrun", d0, a0 + 1);
    cmp_seq("underrun", base);
    check("underrun_done", n_done - d0, 0);
    check("underrun_abort", n_abort - a0, 1);
    check("underrun_busy", busy, 0);

    // Abort during a 6-byte frame after byte 3; bytes 4..6 dropped.
    base = cap.size(); d0 = n_done; a0 = n_abort;
    exp_q.delete();
    exp_q.push_back(9'h07E); exp_q.push_back(9'h1B1); exp_q.push_back(9'h1B2);
    exp_q.push_back(9'h1B3); exp_q.push_back(9'h0FF);
    push_byte(8'hB1, 1'b0);
    push_byte(8'hB2, 1'b0);
    push_byte(8'hB3, 1'b0);
    abort = 1'b1;
    push_byte(8'hB4, 1'b0);
    abort = 1'b0;
    push_byte(8'hB5, 1'b0);
    push_byte(8'hB6, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (10) @(negedge clk);
    cmp_seq("abort", base);
    check("abort_done", n_done - d0, 0);
    check("abort_pulse", n_abort - a0, 1);
    check("abort_busy", busy, 0);

    base = cap.size(); d0 = n_done; a0 = n_abort;
    exp_q.delete();
    exp_frame(3);
    send_frame(3);
    in_valid = 1'b0; in_last = 1'b0;
    wait_pulses("post_abort", d0 + 1, a0);
    cmp_seq("post_abort", base);

    // Back-to-back frames with in_valid held between them.
    base = cap.size(); d0 = n_done; a0 = n_abort;
    exp_q.delete();
    exp_frame(3);
    exp_frame(1);
    send_frame(3);
    send_frame(1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_pulses("b2b", d0 + 2, a0);
    cmp_seq("b2b", base);
    check("b2b_done", n_done - d0, 2);

    // Reset mid-payload.
    d0 = n_done; a0 = n_abort;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_ser_data", ser_data, 8'hFF);
    check("midrst_strobe", ser_strobe, 0);
    check("midrst_stuff", ser_stuff, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    base = cap.size();
    exp_q.delete();
    exp_frame(3);
    send_frame(3);
    in_valid = 1'b0; in_last = 1'b0;
    wait_pulses("postrst", d0 + 1, a0);
    cmp_seq("postrst", base);
    check("postrst_done", n_done - d0, 1);
    check("postrst_abort", n_abort - a0, 0);

    check("no_double_strobe", dbl, 0);
    check("idleflags_only_7e", s2_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
